fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  discard all queued and incoming entries (jump taken).
REQ-006 in_valid  input  1  upstream fetch word valid.
REQ-007 in_instr  input  [31:2]  expanded 32-bit instruction, bits 1:0 implied 2'b11.
REQ-008 in_pc  input  XLEN  PC of in_instr.
REQ-009 in_inc_pc  input  XLEN  PC of the next sequential instruction.
REQ-010 in_ready  output  1  queue can accept an entry this cycle.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_instr  output  [31:2]  head instruction, NOP when empty.
REQ-013 out_pc  output  XLEN  head PC.
REQ-014 out_inc_pc  output  XLEN  head next-sequential PC.
REQ-015 out_ready  input  1  decode consumes head this cycle (low = stall).

Function
REQ-016 Push on posedge when in_valid & in_ready & !flush; entry {in_instr, in_pc, in_inc_pc} written at tail.
REQ-017 Pop on posedge when out_valid & out_ready & !flush; head advances.
REQ-018 in_ready shall be !full, with full = (count == DEPTH); no combinational path from out_ready to in_ready.
REQ-019 No bypass: an entry pushed at edge N is visible on outputs from edge N onward (1-cycle latency, empty -> out_valid on next cycle).
REQ-020 Simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
REQ-021 count width $clog2(DEPTH+1); head/tail pointers $clog2(DEPTH) bits, wrapping modulo DEPTH with no skipped slot.
REQ-022 out_valid = (count != 0); outputs driven from head storage, combinationally.
REQ-023 When empty: out_instr = NOP ('h4, i.e. addi x0,x0,0 >> 2), out_pc and out_inc_pc = 0.
REQ-024 flush has priority: count, head and tail cleared to 0 at next edge; any same-cycle push and pop are discarded.
REQ-025 During the flush cycle outputs still reflect the pre-flush head; from the following cycle out_valid = 0.
REQ-026 in_valid while full: entry not accepted, no state change; upstream must hold.
REQ-027 out_ready while empty: no state change, count never underflows.
REQ-028 Storage contents need no reset; only valid-tracking state does.

Reset
REQ-029 reset high at posedge clears count, head and tail to 0; reset has priority over flush, push and pop.
REQ-030 Reset values: out_valid = 0, out_instr = 'h4, out_pc = 0, out_inc_pc = 0, in_ready = 1.
REQ-031 Reset asserted mid-operation discards all entries; first push after reset deasserts is accepted in the first cycle with reset low.

Structure
REQ-032 Shared core package holds NOP_INSTR constant ('h4, width [31:2]) and fetch_pkt_t struct {instr[31:2], pc, inc_pc}.
REQ-033 Single module; storage as an unpacked array of fetch_pkt_t, no sub-module required.
REQ-034 Pointer/count logic in one always_ff, output muxing in always_comb.

Verification
REQ-035 Reset, then push 0x1000/0x1004/0x1008 with out_ready=0 -> count 3, out_pc=0x1000, in_ready=1; pulse out_ready three cycles -> heads 0x1000, 0x1004, 0x1008, then out_valid=0, out_instr='h4.
REQ-036 Push 4 entries with out_ready=0 -> in_ready=0; 5th in_valid held -> not accepted; one pop -> in_ready=1 next cycle, 5th accepted, order preserved.
REQ-037 Continuous in_valid and out_ready for 20 cycles, PCs 0x0..0x4C -> one entry per cycle, count constant at 1, pointers wrap past DEPTH, no loss or duplication.
REQ-038 Queue holding 3 entries, flush together with in_valid and out_ready -> next cycle count 0, out_valid=0, pushed entry absent; following push of 0x2000 appears at head one cycle later.
REQ-039 Queue holding 2 entries, reset asserted together with flush and push -> out_valid=0, out_instr='h4, in_ready=1 after edge.
REQ-040 Empty queue, out_ready=1, in_valid=0 for 5 cycles -> out_valid stays 0, no underflow; next push appears after exactly one cycle.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared core types for the fetch queue: the queued packet layout and the
// instruction word presented to decode when nothing is queued.
package fetch_queue_pkg;

    localparam int CORE_XLEN = 32;

    // addi x0,x0,0 with the implied 2'b11 low bits stripped off
    localparam logic [31:2] NOP_INSTR = 30'h4;

    typedef struct packed {
        logic [31:2]          instr;
        logic [CORE_XLEN-1:0] pc;
        logic [CORE_XLEN-1:0] inc_pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: upstream push side and downstream head side.
interface fetch_queue_if #(
    parameter int XLEN = 32
);

    logic            in_valid;
    logic [31:2]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inc_pc;
    logic            in_ready;

    logic            out_valid;
    logic [31:2]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inc_pc;
    logic            out_ready;

    // The fetch/decode pair drives the queue through master; the queue is slave
    modport master (
        output in_valid, in_instr, in_pc, in_inc_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_inc_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_inc_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_inc_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Small circular instruction queue between fetch and decode: no bypass,
// flush on taken jumps, head presented combinationally from storage.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    fetch_queue_if.slave  bus
);

    // DEPTH must be a power of two (>= 2) so pointers wrap by plain overflow
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    fetch_pkt_t       r_mem [0:DEPTH-1];

    logic       w_full;
    logic       w_not_empty;
    logic       w_push;
    logic       w_pop;
    fetch_pkt_t w_in_pkt;
    fetch_pkt_t w_head_pkt;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_not_empty = (r_count != '0);
    assign w_push      = bus.in_valid & ~w_full & ~flush;
    assign w_pop       = w_not_empty & bus.out_ready & ~flush;

    assign w_in_pkt.instr  = bus.in_instr;
    assign w_in_pkt.pc     = CORE_XLEN'(bus.in_pc);
    assign w_in_pkt.inc_pc = CORE_XLEN'(bus.in_inc_pc);
    assign w_head_pkt      = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; only the pointers decide validity
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_tail] <= w_in_pkt;
        end
    end

    always_comb begin
        bus.in_ready   = ~w_full;
        bus.out_valid  = w_not_empty;
        bus.out_instr  = NOP_INSTR;
        bus.out_pc     = '0;
        bus.out_inc_pc = '0;
        if (w_not_empty) begin
            bus.out_instr  = w_head_pkt.instr;
            bus.out_pc     = XLEN'(w_head_pkt.pc);
            bus.out_inc_pc = XLEN'(w_head_pkt.inc_pc);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand-derived vector table for the directed scenarios
// plus a queue scoreboard that tracks every accepted entry through the head.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [31:0] pc;
        logic        ev;
        logic        er;
        logic [31:0] epc;
    } vec_t;

    vec_t       vecs[$];
    fetch_pkt_t sb[$];

    function automatic logic [31:2] instrOf(input logic [31:0] pc);
        logic [29:0] mask;
        mask = 30'h2AAAAAAA;
        return pc[31:2] ^ mask;
    endfunction

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic ordy, input logic [31:0] pc,
                                input logic ev, input logic er, input logic [31:0] epc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc;
        v.ev = ev; v.er = er; v.epc = epc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One cycle: drive at negedge, compare the pre-edge view against the
    // scoreboard head, then advance the scoreboard the way the edge should.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic ordy, input logic [31:0] pc);
        logic       mValid;
        logic       mReady;
        fetch_pkt_t pkt;
        @(negedge clk);
        reset         = rst;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_instr  = instrOf(pc);
        bus.in_inc_pc = pc + 32'd4;
        bus.out_ready = ordy;
        #1;
        mValid = (sb.size() != 0);
        mReady = (sb.size() < DEPTH);
        checkOutput("sb_out_valid", {31'd0, bus.out_valid}, {31'd0, mValid});
        checkOutput("sb_in_ready", {31'd0, bus.in_ready}, {31'd0, mReady});
        if (mValid) begin
            checkOutput("sb_instr", {2'b00, bus.out_instr}, {2'b00, sb[0].instr});
            checkOutput("sb_pc", bus.out_pc, sb[0].pc);
            checkOutput("sb_inc_pc", bus.out_inc_pc, sb[0].inc_pc);
        end else begin
            checkOutput("sb_nop_instr", {2'b00, bus.out_instr}, {2'b00, NOP_INSTR});
            checkOutput("sb_nop_pc", bus.out_pc, 32'd0);
            checkOutput("sb_nop_inc_pc", bus.out_inc_pc, 32'd0);
        end
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (ordy && mValid) begin
                void'(sb.pop_front());
            end
            if (iv && mReady) begin
                pkt.instr  = instrOf(pc);
                pkt.pc     = pc;
                pkt.inc_pc = pc + 32'd4;
                sb.push_back(pkt);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.in_inc_pc = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Fill, hold with out_ready low, then drain in order
        vecs.push_back(mk(0,0,1,0,32'h1000, 0,1,32'h0));
        vecs.push_back(mk(0,0,1,0,32'h1004, 1,1,32'h1000));
        vecs.push_back(mk(0,0,1,0,32'h1008, 1,1,32'h1000));
        vecs.push_back(mk(0,0,0,0,32'h0,    1,1,32'h1000));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h1000));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h1004));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h1008));
        vecs.push_back(mk(0,0,0,0,32'h0,    0,1,32'h0));
        // Full queue back-pressure; held 5th entry goes in after one pop
        vecs.push_back(mk(0,0,1,0,32'h1100, 0,1,32'h0));
        vecs.push_back(mk(0,0,1,0,32'h1104, 1,1,32'h1100));
        vecs.push_back(mk(0,0,1,0,32'h1108, 1,1,32'h1100));
        vecs.push_back(mk(0,0,1,0,32'h110C, 1,1,32'h1100));
        vecs.push_back(mk(0,0,1,0,32'h1110, 1,0,32'h1100));
        vecs.push_back(mk(0,0,1,0,32'h1110, 1,0,32'h1100));
        vecs.push_back(mk(0,0,1,1,32'h1110, 1,0,32'h1100));
        vecs.push_back(mk(0,0,1,0,32'h1110, 1,1,32'h1104));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,0,32'h1104));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h1108));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h110C));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h1110));
        vecs.push_back(mk(0,0,0,0,32'h0,    0,1,32'h0));
        // Flush with 3 entries, same-cycle push and pop discarded
        vecs.push_back(mk(0,0,1,0,32'h2100, 0,1,32'h0));
        vecs.push_back(mk(0,0,1,0,32'h2104, 1,1,32'h2100));
        vecs.push_back(mk(0,0,1,0,32'h2108, 1,1,32'h2100));
        vecs.push_back(mk(0,1,1,1,32'h210C, 1,1,32'h2100));
        vecs.push_back(mk(0,0,1,0,32'h2000, 0,1,32'h0));
        vecs.push_back(mk(0,0,0,0,32'h0,    1,1,32'h2000));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h2000));
        // Reset beats flush and push; first push after reset is accepted
        vecs.push_back(mk(0,0,1,0,32'h3000, 0,1,32'h0));
        vecs.push_back(mk(0,0,1,0,32'h3004, 1,1,32'h3000));
        vecs.push_back(mk(1,1,1,1,32'h3008, 1,1,32'h3000));
        vecs.push_back(mk(0,0,1,0,32'h3100, 0,1,32'h0));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h3100));
        // Popping an empty queue must not underflow
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(mk(0,0,0,1,32'h0, 0,1,32'h0));
        end
        vecs.push_back(mk(0,0,1,1,32'h4000, 0,1,32'h0));
        vecs.push_back(mk(0,0,0,1,32'h0,    1,1,32'h4000));
        vecs.push_back(mk(0,0,0,0,32'h0,    0,1,32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].pc);
            checkOutput($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].ev});
            checkOutput($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].er});
            checkOutput($sformatf("vec%0d_out_pc", i), bus.out_pc, vecs[i].epc);
        end

        // Streaming: one in, one out per cycle, pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'(i * 4));
            if (i > 0) begin
                checkOutput($sformatf("stream%0d_pc", i), bus.out_pc, 32'((i - 1) * 4));
                checkOutput($sformatf("stream%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("stream_last_pc", bus.out_pc, 32'h4C);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("stream_drained", {31'd0, bus.out_valid}, 32'd0);

        // Random traffic with occasional flushes, scoreboard only
        for (int i = 0; i < 120; i++) begin
            applyStimulus(1'b0, ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) != 0, 32'h8000 + 32'(i * 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
